// File: rtl/tick_event_counter_pkg.sv
// Shared constants for the tick event counter: BCD digit limits, default sizing
// and the single-digit step rule used by every counter digit.
package tick_event_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam int DEFAULT_NUM_DIGITS  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Out-of-range codes are folded back into 0..9 so a digit can never stick on an illegal value.
    function automatic logic [3:0] bcd_step(input logic [3:0] digit, input logic up);
        logic [3:0] next_digit;
        if (up) begin
            next_digit = (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
        end else begin
            next_digit = ((digit == BCD_MIN) || (digit > BCD_MAX)) ? BCD_MAX : digit - 4'd1;
        end
        return next_digit;
    endfunction

endpackage

// File: rtl/tick_event_counter_digit.sv
// One BCD counter digit: steps up or down by one when told to, and flags when
// the next step in the current direction will wrap and carry/borrow.
module bcd_digit
    import tick_event_counter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic       up_down,
    output logic [3:0] digit,
    output logic       carry
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit <= BCD_MIN;
        end else if (clear) begin
            digit <= BCD_MIN;
        end else if (step) begin
            digit <= bcd_step(digit, up_down);
        end
    end

    // Carry is a lookahead on the current value, so the chain ripples combinationally between digits.
    assign carry = up_down ? (digit == BCD_MAX) : (digit == BCD_MIN);

endmodule

// File: rtl/tick_event_counter.sv
// Receives the tick line, synchronises it, detects rising edges and counts them
// in a cascadable multi-digit BCD up/down counter.
module tick_event_counter
    import tick_event_counter_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    edge_seen,
    output logic                    carry_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   history_q;
    logic                   armed_q;
    logic                   sync_last;
    logic                   edge_det;
    logic [NUM_DIGITS:0]    chain;
    logic [NUM_DIGITS-1:0]  digit_carry;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // fill_q marks when sync_last carries a real sample rather than the reset zero,
    // so a tick held high across reset release cannot arm the detector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            fill_q    <= '0;
            history_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            history_q <= sync_last;
            if (fill_q[SYNC_STAGES-1] && !sync_last) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign edge_det = sync_last & ~history_q & armed_q;
    assign chain[0] = edge_det & enable;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clock   (clock),
            .reset   (reset),
            .clear   (clear),
            .step    (chain[i]),
            .up_down (up_down),
            .digit   (bcd_out[4*i +: 4]),
            .carry   (digit_carry[i])
        );
        assign chain[i+1] = chain[i] & digit_carry[i];
    end

    // A step that reaches past the top digit is a full wrap; clear discards it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_seen <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            edge_seen <= edge_det;
            carry_out <= !clear && chain[NUM_DIGITS];
        end
    end

endmodule

// File: tb/tb_tick_event_counter.sv
// Self-checking bench for tick_event_counter: directed scenarios with literal
// expectations plus a randomized phase, all compared against a behavioural model.
module tb_tick_event_counter;

    localparam int NUM_DIGITS  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MODULUS     = 10000;

    logic                    clock   = 1'b0;
    logic                    reset   = 1'b1;
    logic                    tick_in = 1'b0;
    logic                    enable  = 1'b0;
    logic                    up_down = 1'b1;
    logic                    clear   = 1'b0;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic                    edge_seen;
    logic                    carry_out;

    int total      = 0;
    int bad        = 0;
    int edge_count = 0;

    tick_event_counter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick_in   (tick_in),
        .enable    (enable),
        .up_down   (up_down),
        .clear     (clear),
        .bcd_out   (bcd_out),
        .edge_seen (edge_seen),
        .carry_out (carry_out)
    );

    always #20 clock = ~clock;

    // Model: the count is a plain integer modulo 10^N; a rising edge is a 0 then 1
    // pair of tick samples both taken after reset release, acted on SYNC_STAGES edges later.
    int model_count         = 0;
    bit model_edge          = 1'b0;
    bit model_carry         = 1'b0;
    bit prev_sample         = 1'b0;
    int samples_since_reset = 0;
    bit rise_delay[$];

    function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int value);
        logic [4*NUM_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_count         = 0;
            model_edge          = 1'b0;
            model_carry         = 1'b0;
            prev_sample         = 1'b0;
            samples_since_reset = 0;
            rise_delay.delete();
            for (int i = 0; i < SYNC_STAGES; i++) rise_delay.push_back(1'b0);
        end else begin
            bit rise;
            bit ev;
            rise = (samples_since_reset >= 1) && !prev_sample && (tick_in == 1'b1);
            prev_sample = tick_in;
            samples_since_reset++;
            ev = rise_delay.pop_front();
            rise_delay.push_back(rise);
            model_edge  = ev;
            model_carry = 1'b0;
            if (clear) begin
                model_count = 0;
            end else if (ev && enable) begin
                if (up_down) begin
                    if (model_count == MODULUS - 1) begin
                        model_count = 0;
                        model_carry = 1'b1;
                    end else begin
                        model_count++;
                    end
                end else begin
                    if (model_count == 0) begin
                        model_count = MODULUS - 1;
                        model_carry = 1'b1;
                    end else begin
                        model_count--;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Every cycle the outputs are compared with the model, away from the rising edge.
    always @(negedge clock) begin
        checkOutput("bcd_out", 32'(bcd_out), 32'(to_bcd(model_count)));
        checkOutput("edge_seen", 32'(edge_seen), 32'(model_edge));
        checkOutput("carry_out", 32'(carry_out), 32'(model_carry));
    end

    always @(negedge clock) begin
        if (edge_seen === 1'b1) edge_count++;
    end

    task automatic applyStimulus(input logic t, input logic en, input logic ud, input logic clr);
        @(negedge clock);
        tick_in = t;
        enable  = en;
        up_down = ud;
        clear   = clr;
    endtask

    // Raises tick, reports the outputs on the cycle edge_seen fires and how many
    // falling edges that took, then drops tick and leaves a low gap.
    task automatic pulseEdge(output logic [15:0] seen_bcd, output logic seen_carry, output int latency);
        bit found;
        found      = 1'b0;
        seen_bcd   = '0;
        seen_carry = 1'b0;
        latency    = 0;
        applyStimulus(1'b1, enable, up_down, 1'b0);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (edge_seen === 1'b1) begin
                found      = 1'b1;
                seen_bcd   = bcd_out;
                seen_carry = carry_out;
                latency    = i + 1;
            end
        end
        if (!found) checkOutput("edge_timeout", 32'd0, 32'd1);
        applyStimulus(1'b0, enable, up_down, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic countEdges(input int n);
        logic [15:0] b;
        logic        c;
        int          l;
        for (int i = 0; i < n; i++) pulseEdge(b, c, l);
    endtask

    task automatic slowPulse();
        @(negedge clock);
        #5 tick_in = 1'b1;
        #100 tick_in = 1'b0;
        #100;
    endtask

    initial begin
        logic [15:0] b;
        logic        c;
        int          lat;
        int          edges_before;

        #3 reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("reset_edge", 32'(edge_seen), 32'h0);
        checkOutput("reset_carry", 32'(carry_out), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] three slow ticks, counting up");
        edges_before = edge_count;
        repeat (3) slowPulse();
        repeat (4) @(negedge clock);
        checkOutput("t1_count", 32'(bcd_out), 32'h0003);
        checkOutput("t1_edges", 32'(edge_count - edges_before), 32'd3);

        $display("[TB] wrap down from zero and back up");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pulseEdge(b, c, lat);
        checkOutput("down_wrap_bcd", 32'(b), 32'h9999);
        checkOutput("down_wrap_carry", 32'(c), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        pulseEdge(b, c, lat);
        checkOutput("up_wrap_bcd", 32'(b), 32'h0000);
        checkOutput("up_wrap_carry", 32'(c), 32'd1);
        countEdges(9);
        pulseEdge(b, c, lat);
        checkOutput("digit_carry_bcd", 32'(b), 32'h0010);
        checkOutput("digit_carry_co", 32'(c), 32'd0);
        checkOutput("edge_latency", 32'(lat), 32'd3);

        $display("[TB] borrow across two digits");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        countEdges(100);
        checkOutput("preload_100", 32'(bcd_out), 32'h0100);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pulseEdge(b, c, lat);
        checkOutput("borrow_bcd", 32'(b), 32'h0099);
        checkOutput("borrow_carry", 32'(c), 32'd0);

        $display("[TB] enable low, then clear against an edge");
        edges_before = edge_count;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        countEdges(2);
        checkOutput("hold_edges", 32'(edge_count - edges_before), 32'd2);
        checkOutput("hold_bcd", 32'(bcd_out), 32'h0099);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        countEdges(42);
        checkOutput("preload_42", 32'(bcd_out), 32'h0042);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        checkOutput("clear_edge_seen", 32'(edge_seen), 32'd1);
        checkOutput("clear_bcd", 32'(bcd_out), 32'h0000);
        checkOutput("clear_carry", 32'(carry_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clock);

        $display("[TB] tick held high across reset release");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        #5 reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        edges_before = edge_count;
        repeat (8) @(negedge clock);
        checkOutput("held_high_edges", 32'(edge_count - edges_before), 32'd0);
        checkOutput("held_high_bcd", 32'(bcd_out), 32'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        pulseEdge(b, c, lat);
        checkOutput("rearm_bcd", 32'(b), 32'h0001);

        $display("[TB] reset in the middle of counting");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        countEdges(57);
        checkOutput("preload_57", 32'(bcd_out), 32'h0057);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #10 reset = 1'b0;
        #1;
        checkOutput("async_bcd", 32'(bcd_out), 32'h0000);
        checkOutput("async_edge", 32'(edge_seen), 32'd0);
        checkOutput("async_carry", 32'(carry_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        edges_before = edge_count;
        repeat (6) @(negedge clock);
        checkOutput("post_reset_edges", 32'(edge_count - edges_before), 32'd0);
        checkOutput("post_reset_bcd", 32'(bcd_out), 32'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        pulseEdge(b, c, lat);
        checkOutput("post_reset_rearm", 32'(b), 32'h0001);

        $display("[TB] randomized phase");
        for (int i = 0; i < 3000; i++) begin
            logic t;
            t = ($urandom_range(0, 2) == 0) ? ~tick_in : tick_in;
            applyStimulus(t, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 63) == 0));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_event_counter.md
Name: tick_event_counter

Overview:
- Receiving end of the tick line driven by the tick generator `T`, whose `out` output produces one rising edge per event.
- Synchronises the incoming tick level, detects its rising edges and counts them in a multi-digit BCD up/down counter.
- The BCD outputs feed the display drivers; `carry_out` cascades to a further counter stage.
- Sits between `T` and the seven-segment decode logic in the miniproject top level.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- SYNC_STAGES, 2, synchroniser depth on `tick_in` (minimum 2).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick_in  input  1  tick level from `T.out`; may be asynchronous to `clock`.
- enable  input  1  1 = count detected edges; 0 = hold count.
- up_down  input  1  1 = count up, 0 = count down; sampled on the counting edge.
- clear  input  1  synchronous clear of the count.
- bcd_out  output  4*NUM_DIGITS  count; digit 0 in bits [3:0].
- edge_seen  output  1  one-cycle pulse per detected rising edge.
- carry_out  output  1  one-cycle pulse on wrap (up: all-9s to 0; down: 0 to all-9s).

Behaviour:
- Reset (reset=0, asynchronous): bcd_out=0, edge_seen=0, carry_out=0, all synchroniser flops=0, history flop=0, armed=0.
- Synchroniser: `tick_in` passes through SYNC_STAGES flops, then one history flop. The detected edge is `sync_last & ~history & armed`.
- Arming:
  - armed sets on the first cycle sync_last=0 after reset release, then stays set until the next reset.
  - A tick_in held high across reset release is never counted.
- Latency: tick_in rises before clock edge k (and is sampled there). edge_seen asserts, and bcd_out updates, at edge k+SYNC_STAGES. Both effects land on the same edge.
- Pulse width:
  - edge_seen is high for exactly one cycle per rising edge, regardless of how long tick_in stays high.
  - tick_in must be low for at least 1 synchronised cycle between events; shorter low gaps are not guaranteed to be detected.
- Count priority per cycle (highest first):
  1. clear=1: bcd_out <= 0 and carry_out <= 0. edge_seen still pulses if an edge is detected; that edge is discarded.
  2. Edge detected and enable=1: count by one in the direction given by up_down.
  3. Otherwise: hold. With enable=0, edge_seen still pulses but the count does not change.
- Up count:
  - Digit i increments when all lower digits are 9. A digit at 9 wraps to 0 and carries.
  - All digits 9 -> all 0, with carry_out=1 for that one cycle.
- Down count:
  - A digit at 0 becomes 9 and borrows.
  - All digits 0 -> all 9, with carry_out=1 for that one cycle.
- Digit values are always 0..9; no illegal BCD code is ever produced.
- carry_out is registered and coincides with the wrapped bcd_out value; it is 0 in every other cycle.
- Reset mid-operation: all outputs go to 0 immediately (asynchronous). Counting resumes only after re-arming.

Decomposition:
- Shared package (project constants file) holds:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0
  - default NUM_DIGITS and SYNC_STAGES
- Sub-module `bcd_digit`, one instance per digit via generate:
  - Inputs: clock, reset, clear, step (edge & enable & carry-in), up_down.
  - Outputs: 4-bit digit value, carry-chain output (digit at 9 when up, at 0 when down).
- Top level holds the synchroniser, history and armed flops, edge detection and the carry_out register.

Test Plan:
1. Reset, then 3 tick_in pulses (high 100 ns, low 100 ns, 40 ns clock), enable=1, up_down=1 -> bcd_out 0x0000 -> 0x0003. edge_seen pulses 3 times, each 1 cycle; each count change occurs 2 clock edges after the sampling edge.
2. Preload via 9999 up-edges (or forced start 0x9999), one more edge -> bcd_out=0x0000, carry_out=1 for exactly that cycle. From 0x0009, one edge -> 0x0010 and carry_out=0.
3. Down count from 0x0000, one edge -> 0x9999 with carry_out=1. From 0x0100, one edge -> 0x0099.
4. enable=0 with 2 edges -> edge_seen pulses twice, bcd_out unchanged. clear=1 in the same cycle as an edge at 0x0042 -> bcd_out=0x0000, carry_out=0.
5. tick_in held high while reset deasserts -> no edge_seen, count stays 0. tick_in low then high -> 1 edge, count=0x0001.
6. reset asserted mid-count at 0x0057 between clock edges -> outputs read 0 before the next clock edge, with no further count until re-armed.
